// File: rtl/uart_pkg.sv
// Shared constants and state type for the telemetry-buffer read scheduler and
// the UART byte loaders that consume its read strobes.
package uart_pkg;

    localparam int unsigned N_CH_DEF     = 5;
    localparam int unsigned WORDS_DEF    = 18;
    localparam int unsigned ADR_W_DEF    = 5;
    localparam int unsigned SLOT_LEN_DEF = 64;
    localparam int unsigned RD_START_DEF = 40;
    localparam int unsigned RD_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSlot,
        StDone
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: grants the first requester at or after the
// pointer, wrapping around the channel count.
module rr_arbiter #(
    parameter int unsigned N_CH = 5,
    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_CH-1:0]  gnt_o,
    output logic             any_o
);

    logic              found;
    int unsigned       idx;
    logic [PTR_W-1:0]  sel;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(ptr_i) + i) % N_CH;
            sel = PTR_W'(idx);
            if (!found && req_i[sel]) begin
                gnt_o[sel] = 1'b1;
                found      = 1'b1;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/uart_rd_sched.sv
// Shares one telemetry-buffer read port among N_CH UART channels: synchronises
// frame strobes, arbitrates round-robin and paces one read per word slot.
module uart_rd_sched
    import uart_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEF,
    parameter int unsigned WORDS    = WORDS_DEF,
    parameter int unsigned ADR_W    = ADR_W_DEF,
    parameter int unsigned SLOT_LEN = SLOT_LEN_DEF,
    parameter int unsigned RD_START = RD_START_DEF,
    parameter int unsigned RD_WIDTH = RD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  strob,
    output logic [N_CH-1:0]  rd,
    output logic [ADR_W-1:0] rd_adr,
    output logic [N_CH-1:0]  grant,
    output logic             busy,
    output logic [N_CH-1:0]  done
);

    localparam int unsigned SLOT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int unsigned PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
    localparam logic [SLOT_W-1:0] RD_FIRST  = SLOT_W'(RD_START);
    localparam logic [SLOT_W-1:0] RD_LAST   = SLOT_W'(RD_START + RD_WIDTH - 1);
    localparam logic [ADR_W-1:0]  WORD_LAST = ADR_W'(WORDS - 1);

    logic [N_CH-1:0]   sync1_q, sync2_q, sync3_q, rise_q;
    logic [N_CH-1:0]   pending_q, pending_d, clr;
    logic [N_CH-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d, owner_idx;
    logic [ADR_W-1:0]  word_q, word_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    sched_state_e      state_q, state_d;

    logic [N_CH-1:0]   arb_gnt;
    logic              arb_any;
    logic              in_slot, rd_on;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req_i (pending_q),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .any_o (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            rise_q    <= '0;
            pending_q <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            word_q    <= '0;
            slot_q    <= '0;
            state_q   <= StIdle;
        end else begin
            sync1_q   <= strob;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            rise_q    <= sync2_q & ~sync3_q;
            pending_q <= pending_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            word_q    <= word_d;
            slot_q    <= slot_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (owner_q[k]) owner_idx = PTR_W'(k);
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        slot_d  = slot_q;
        clr     = '0;
        case (state_q)
            StIdle: begin
                if (arb_any) begin
                    // Pending is dropped at grant so a re-request raised during
                    // service survives and earns another frame.
                    clr     = arb_gnt;
                    owner_d = arb_gnt;
                    word_d  = '0;
                    slot_d  = '0;
                    state_d = StSlot;
                end
            end
            StSlot: begin
                if (slot_q == SLOT_LAST) begin
                    if (word_q != WORD_LAST) begin
                        word_d = word_q + ADR_W'(1);
                        slot_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            StDone: begin
                ptr_d   = (owner_idx == PTR_W'(N_CH - 1)) ? '0 : owner_idx + PTR_W'(1);
                owner_d = '0;
                word_d  = '0;
                slot_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        pending_d = (pending_q & ~clr) | rise_q;
    end

    always_comb begin
        in_slot = (state_q == StSlot);
        rd_on   = in_slot && (slot_q >= RD_FIRST) && (slot_q <= RD_LAST);
        busy    = in_slot;
        grant   = in_slot ? owner_q : '0;
        rd      = rd_on ? owner_q : '0;
        rd_adr  = in_slot ? word_q : '0;
        done    = (state_q == StDone) ? owner_q : '0;
    end

endmodule
